projection_scheduler: RTL and testbench
=======================================

PROJECTION_SCHEDULER -- requirements
Module: projection_scheduler

Interface
REQ-001 SHALL have parameter COORD_WIDTH, default 32, Q16.16 coordinate width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, triangle memory address width.
REQ-003 SHALL have parameter MEM_LATENCY, default 2, cycles from mem_addr to valid mem_data (range 1-7).
REQ-004 SHALL have ports:
- clk_in  in  1  sole clock; one clock, reset is asynchronous and active-high.
- rst_in  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that begins a frame.
- tri_count  in  ADDR_WIDTH+1  triangles in the frame, sampled on accepted frame_start.
- mem_addr  out  ADDR_WIDTH  triangle memory read address.
- mem_data  in  9*COORD_WIDTH  three vertices {v2,v1,v0}, each {z,y,x}.
- proj_start  out  1  one-cycle start pulse to the projection unit.
- proj_verts  out  9*COORD_WIDTH  registered triangle presented to the projection unit.
- proj_busy  in  1  projection unit busy.
- proj_done  in  1  projection unit done (may stay high 2 cycles).
- proj_valid  in  1  result valid, qualified by proj_done.
- proj_status  in  2  0 ok, 1 clipped, 2 divide error.
- proj_result  in  9*COORD_WIDTH  projected triangle.
- out_tri  out  9*COORD_WIDTH  projected triangle to the rasterizer.
- out_valid  out  1  out_tri valid.
- out_ready  in  1  rasterizer accepts out_tri.
- frame_busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at frame end.
- culled_count  out  ADDR_WIDTH+1  triangles discarded this frame.

Function
REQ-005 SHALL implement states IDLE, FETCH, LAUNCH, WAIT, EMIT, NEXT, FINISH.
REQ-006 IDLE: on frame_start SHALL latch tri_count, clear index and culled_count, and assert frame_busy; go to FINISH if tri_count==0, else to FETCH.
REQ-007 SHALL ignore frame_start when not in IDLE.
REQ-008 FETCH: SHALL drive mem_addr=index, wait exactly MEM_LATENCY cycles, then register mem_data into proj_verts and go to LAUNCH.
REQ-009 LAUNCH: SHALL hold until proj_busy==0 and proj_done==0, then assert proj_start for exactly one cycle and go to WAIT.
REQ-010 WAIT: SHALL ignore proj_done in the first cycle after proj_start; afterwards, on first proj_done==1:
- proj_valid==1: register proj_result into out_tri and go to EMIT.
- proj_valid==0: increment culled_count (status 1 or 2 treated alike) and go to NEXT.
REQ-011 EMIT: out_valid SHALL be 1 and out_tri SHALL stay stable until the cycle out_valid&&out_ready; then out_valid SHALL go 0 and the FSM SHALL go to NEXT.
REQ-012 NEXT: SHALL increment index; go to FINISH if index+1==latched count, else to FETCH.
REQ-013 FINISH: SHALL pulse frame_done for one cycle, deassert frame_busy, and go to IDLE; culled_count SHALL hold until the next accepted frame_start.
REQ-014 Only one triangle SHALL be in flight; proj_verts SHALL be constant from LAUNCH until WAIT exits.
REQ-015 proj_start and frame_done SHALL never be high in consecutive cycles.
REQ-016 Index arithmetic SHALL be ADDR_WIDTH+1 bits; tri_count=2^ADDR_WIDTH SHALL process all addresses with no wrap before FINISH.
REQ-017 out_ready high outside EMIT SHALL have no effect.

Reset
REQ-018 rst_in SHALL asynchronously force IDLE with mem_addr, proj_start, proj_verts, out_tri, out_valid, frame_busy, frame_done, culled_count and index at 0.
REQ-019 Reset mid-frame SHALL abandon the frame with no frame_done pulse; the next frame_start after release SHALL start a fresh frame.

Verification
REQ-020 tri_count=3, projector model returns valid for all, out_ready=1 -> three out_valid handshakes with addresses 0,1,2, then frame_done, culled_count=0.
REQ-021 tri_count=4, triangle 1 returns proj_valid=0 status=1 and triangle 3 returns status=2 -> two out handshakes, culled_count=2, one frame_done.
REQ-022 tri_count=0 -> frame_done exactly 2 cycles after frame_start, no proj_start.
REQ-023 tri_count=2, out_ready low for 10 cycles in EMIT -> out_tri stable, no second proj_start until the handshake.
REQ-024 proj_done held high 2 cycles each -> exactly one proj_start per triangle, no double count; frame_start pulsed mid-frame ignored.
REQ-025 rst_in asserted while in WAIT -> all outputs 0 immediately (asynchronously), no frame_done; next frame with tri_count=1 completes normally.

Source files
------------

// File: rtl/projection_scheduler.sv
// projection_scheduler
//
// Purpose:
//   Walks a frame of triangles stored in triangle memory, hands them one at a
//   time to a projection unit and forwards every valid projected triangle to
//   the rasterizer. Triangles that the projection unit reports as invalid
//   (clipped or divide error) are dropped and counted.
//
// Ports:
//   clk_in, rst_in   clock; asynchronous active-high reset
//   frame_start      one-cycle pulse, accepted only while idle
//   tri_count        triangles in the frame, sampled with an accepted frame_start
//   mem_addr         triangle memory read address (registered)
//   mem_data         triangle {v2,v1,v0}, each {z,y,x}, valid MEM_LATENCY cycles after mem_addr
//   proj_start       one-cycle launch pulse to the projection unit
//   proj_verts       registered triangle presented to the projection unit
//   proj_busy        projection unit busy
//   proj_done        projection unit done (may stay high for two cycles)
//   proj_valid       projection result valid, qualified by proj_done
//   proj_status      0 ok, 1 clipped, 2 divide error (invalid results are dropped alike)
//   proj_result      projected triangle
//   out_tri          projected triangle towards the rasterizer
//   out_valid        out_tri valid
//   out_ready        rasterizer accepts out_tri
//   frame_busy       frame in progress
//   frame_done       one-cycle pulse at the end of the frame
//   culled_count     triangles dropped in the current/last frame
//   state_dbg        current FSM state encoding
//
// Output handshake: a triangle transfers on a cycle where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low,
// out_tri is held unchanged, and out_valid never drops before the transfer.

module projection_scheduler #(
    parameter int COORD_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int MEM_LATENCY = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       frame_start,
    input  logic [ADDR_WIDTH:0]        tri_count,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic [9*COORD_WIDTH-1:0]   mem_data,
    output logic                       proj_start,
    output logic [9*COORD_WIDTH-1:0]   proj_verts,
    input  logic                       proj_busy,
    input  logic                       proj_done,
    input  logic                       proj_valid,
    input  logic [1:0]                 proj_status,
    input  logic [9*COORD_WIDTH-1:0]   proj_result,
    output logic [9*COORD_WIDTH-1:0]   out_tri,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       frame_busy,
    output logic                       frame_done,
    output logic [ADDR_WIDTH:0]        culled_count,
    output logic [2:0]                 state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_EMIT   = 3'd4,
        S_NEXT   = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_WIDTH:0] count_q;
    logic [ADDR_WIDTH:0] index_q;
    logic [ADDR_WIDTH:0] index_inc;
    logic [2:0]          lat_q;

    // one-cycle strobes from the next-state logic into the datapath
    logic load_frame;
    logic capture;
    logic fire;
    logic take;
    logic cull;
    logic handoff;
    logic advance;
    logic finish;

    // Invalid results are dropped whatever their status code says, so the
    // status only has to be observed, never decoded.
    logic unused_status;
    assign unused_status = ^proj_status;

    // Index arithmetic is one bit wider than the address so that a full
    // 2^ADDR_WIDTH frame terminates on the compare instead of wrapping.
    assign index_inc = index_q + 1'b1;
    assign state_dbg = state_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_frame = 1'b0;
        capture    = 1'b0;
        fire       = 1'b0;
        take       = 1'b0;
        cull       = 1'b0;
        handoff    = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    load_frame = 1'b1;
                    state_d    = (tri_count == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                // mem_addr has been stable since the first FETCH cycle
                if (lat_q == LAT) begin
                    capture = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // a lingering done from the previous triangle must clear first
                if (!proj_busy && !proj_done) begin
                    fire    = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // proj_start is still high in the first WAIT cycle; any done
                // seen then cannot belong to this launch
                if (!proj_start && proj_done) begin
                    if (proj_valid) begin
                        take    = 1'b1;
                        state_d = S_EMIT;
                    end else begin
                        cull    = 1'b1;
                        state_d = S_NEXT;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    handoff = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                advance = 1'b1;
                state_d = (index_inc == count_q) ? S_FINISH : S_FETCH;
            end
            S_FINISH: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q      <= '0;
            index_q      <= '0;
            lat_q        <= '0;
            mem_addr     <= '0;
            proj_start   <= 1'b0;
            proj_verts   <= '0;
            out_tri      <= '0;
            out_valid    <= 1'b0;
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
            culled_count <= '0;
        end else begin
            proj_start <= fire;
            frame_done <= finish;

            if (load_frame) begin
                count_q      <= tri_count;
                index_q      <= '0;
                culled_count <= '0;
                frame_busy   <= 1'b1;
                mem_addr     <= '0;
                lat_q        <= '0;
            end

            if (state_q == S_FETCH && !capture) begin
                lat_q <= lat_q + 1'b1;
            end

            if (capture) begin
                proj_verts <= mem_data;
            end

            if (take) begin
                out_tri   <= proj_result;
                out_valid <= 1'b1;
            end

            if (handoff) begin
                out_valid <= 1'b0;
            end

            if (cull) begin
                culled_count <= culled_count + 1'b1;
            end

            if (advance) begin
                index_q  <= index_inc;
                mem_addr <= index_inc[ADDR_WIDTH-1:0];
                lat_q    <= '0;
            end

            if (finish) begin
                frame_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_projection_scheduler.sv
// tb_projection_scheduler
//
// Purpose:
//   Directed bench for projection_scheduler with a delayed triangle memory,
//   a small projection-unit model and an output scoreboard.
//
// Ports: none (top-level bench).

module tb_projection_scheduler;

    localparam int CW   = 8;
    localparam int AW   = 3;
    localparam int ML   = 2;
    localparam int TW   = 9 * CW;
    localparam int CNTW = AW + 1;
    localparam logic [TW-1:0] RES_MASK = {9{8'h5A}};

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    // ---------------- DUT signals ----------------
    logic            frame_start = 1'b0;
    logic [AW:0]     tri_count   = '0;
    logic [AW-1:0]   mem_addr;
    logic [TW-1:0]   mem_data;
    logic            proj_start;
    logic [TW-1:0]   proj_verts;
    logic            proj_busy   = 1'b0;
    logic            proj_done   = 1'b0;
    logic            proj_valid  = 1'b0;
    logic [1:0]      proj_status = 2'd0;
    logic [TW-1:0]   proj_result = '0;
    logic [TW-1:0]   out_tri;
    logic            out_valid;
    logic            out_ready   = 1'b1;
    logic            frame_busy;
    logic            frame_done;
    logic [AW:0]     culled_count;
    logic [2:0]      state_dbg;

    projection_scheduler #(
        .COORD_WIDTH (CW),
        .ADDR_WIDTH  (AW),
        .MEM_LATENCY (ML)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .frame_start  (frame_start),
        .tri_count    (tri_count),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .proj_start   (proj_start),
        .proj_verts   (proj_verts),
        .proj_busy    (proj_busy),
        .proj_done    (proj_done),
        .proj_valid   (proj_valid),
        .proj_status  (proj_status),
        .proj_result  (proj_result),
        .out_tri      (out_tri),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .frame_busy   (frame_busy),
        .frame_done   (frame_done),
        .culled_count (culled_count),
        .state_dbg    (state_dbg)
    );

    // Triangle i: byte k = {i, k}; bits [6:4] of proj_verts identify the triangle.
    function automatic logic [TW-1:0] tri_word(input int i);
        logic [TW-1:0] w;
        for (int k = 0; k < 9; k++) begin
            w[k*8 +: 8] = 8'((i << 4) | k);
        end
        return w;
    endfunction

    // ---------------- triangle memory, ML-cycle read latency ----------------
    logic [AW-1:0] addr_p1 = '0;
    logic [AW-1:0] addr_p2 = '0;
    always @(posedge clk_in) begin
        addr_p1 <= mem_addr;
        addr_p2 <= addr_p1;
    end
    assign mem_data = tri_word(int'(addr_p2));

    // ---------------- projection unit model ----------------
    logic [7:0]    cull_mask = '0;
    logic [1:0]    cull_stat [8];
    int            done_hold = 1;
    int            verts_err = 0;
    int            pj_cnt    = 0;
    int            pj_left   = 0;
    logic [TW-1:0] pj_tri    = '0;
    logic [2:0]    pj_idx;

    always @(posedge clk_in) begin
        #2;
        if (rst_in) begin
            proj_busy   = 1'b0;
            proj_done   = 1'b0;
            proj_valid  = 1'b0;
            proj_status = 2'd0;
            proj_result = '0;
            pj_cnt      = 0;
            pj_left     = 0;
        end else if (proj_start) begin
            pj_tri    = proj_verts;
            proj_busy = 1'b1;
            pj_cnt    = 3;
        end else if (pj_cnt > 0) begin
            if (proj_verts !== pj_tri) verts_err++;
            pj_cnt--;
            if (pj_cnt == 0) begin
                pj_idx      = pj_tri[6:4];
                proj_busy   = 1'b0;
                proj_done   = 1'b1;
                proj_valid  = !cull_mask[pj_idx];
                proj_status = cull_mask[pj_idx] ? cull_stat[pj_idx] : 2'd0;
                proj_result = pj_tri ^ RES_MASK;
                pj_left     = done_hold - 1;
            end
        end else if (proj_done) begin
            if (pj_left > 0) begin
                pj_left--;
            end else begin
                proj_done   = 1'b0;
                proj_valid  = 1'b0;
                proj_status = 2'd0;
            end
        end
    end

    // ---------------- monitor ----------------
    int            start_cnt  = 0;
    int            done_cnt   = 0;
    int            seq_err    = 0;
    int            stab_err   = 0;
    logic [TW-1:0] got_q[$];
    logic          prev_start = 1'b0;
    logic          prev_done  = 1'b0;
    logic          prev_ov    = 1'b0;
    logic          prev_hs    = 1'b0;
    logic [TW-1:0] prev_tri   = '0;

    always @(negedge clk_in) begin
        if (proj_start) start_cnt++;
        if (frame_done) done_cnt++;
        if ((proj_start && prev_done) || (frame_done && prev_start)) seq_err++;
        if (prev_ov && !prev_hs && (!out_valid || out_tri !== prev_tri)) stab_err++;
        if (out_valid && out_ready) got_q.push_back(out_tri);
        prev_start = proj_start;
        prev_done  = frame_done;
        prev_ov    = out_valid;
        prev_hs    = out_valid && out_ready;
        prev_tri   = out_tri;
    end

    // ---------------- checking helpers ----------------
    int            checks = 0;
    int            errors = 0;
    logic [TW-1:0] exp_q[$];
    int            rd = 0;
    int            s0 = 0;
    int            d0 = 0;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic begin_frame(input int n);
        s0 = start_cnt;
        d0 = done_cnt;
        for (int i = 0; i < n; i++) begin
            if (!cull_mask[i]) exp_q.push_back(tri_word(i) ^ RES_MASK);
        end
        frame_start = 1'b1;
        tri_count   = CNTW'(n);
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (!frame_done && n < budget) begin
            tick();
            n++;
        end
        check(tag, TW'(frame_done), TW'(1));
    endtask

    task automatic end_frame(input string tag, input int exp_starts, input int exp_culled);
        logic [TW-1:0] e;
        logic [TW-1:0] g;
        tick();
        check({tag, " done_one_cycle"}, TW'(frame_done), TW'(0));
        check({tag, " handshakes"}, TW'(got_q.size() - rd), TW'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rd < got_q.size()) ? got_q[rd] : 'x;
            rd++;
            check({tag, " out_tri"}, g, e);
        end
        rd = got_q.size();
        check({tag, " proj_starts"}, TW'(start_cnt - s0), TW'(exp_starts));
        check({tag, " done_pulses"}, TW'(done_cnt - d0), TW'(1));
        check({tag, " culled"}, TW'(culled_count), TW'(exp_culled));
        check({tag, " busy_low"}, TW'(frame_busy), TW'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " state"}, TW'(state_dbg), TW'(0));
        check({tag, " mem_addr"}, TW'(mem_addr), TW'(0));
        check({tag, " proj_start"}, TW'(proj_start), TW'(0));
        check({tag, " proj_verts"}, proj_verts, TW'(0));
        check({tag, " out_tri"}, out_tri, TW'(0));
        check({tag, " out_valid"}, TW'(out_valid), TW'(0));
        check({tag, " frame_busy"}, TW'(frame_busy), TW'(0));
        check({tag, " frame_done"}, TW'(frame_done), TW'(0));
        check({tag, " culled"}, TW'(culled_count), TW'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        for (int i = 0; i < 8; i++) cull_stat[i] = 2'd0;

        // reset state
        repeat (3) tick();
        check_all_zero("reset");
        rst_in = 1'b0;
        tick();

        // three valid triangles, rasterizer always ready
        begin_frame(3);
        wait_done(200, "f3 done_seen");
        end_frame("f3", 3, 0);

        // triangle 1 clipped, triangle 3 divide error
        cull_mask    = 8'b0000_1010;
        cull_stat[1] = 2'd1;
        cull_stat[3] = 2'd2;
        begin_frame(4);
        wait_done(200, "f4 done_seen");
        end_frame("f4", 4, 2);
        repeat (5) tick();
        check("f4 culled_hold", TW'(culled_count), TW'(2));

        // empty frame: frame_done two cycles after frame_start
        cull_mask = '0;
        begin_frame(0);
        check("empty t+1 done", TW'(frame_done), TW'(0));
        check("empty t+1 busy", TW'(frame_busy), TW'(1));
        check("empty culled_cleared", TW'(culled_count), TW'(0));
        tick();
        check("empty t+2 done", TW'(frame_done), TW'(1));
        check("empty t+2 busy", TW'(frame_busy), TW'(0));
        tick();
        check("empty t+3 done", TW'(frame_done), TW'(0));
        check("empty proj_starts", TW'(start_cnt - s0), TW'(0));
        check("empty done_pulses", TW'(done_cnt - d0), TW'(1));

        // back-pressure: rasterizer not ready for 10 cycles
        out_ready = 1'b0;
        begin_frame(2);
        w = 0;
        while (!out_valid && w < 100) begin
            tick();
            w++;
        end
        check("bp valid_seen", TW'(out_valid), TW'(1));
        for (int c = 0; c < 10; c++) begin
            check("bp out_tri_held", out_tri, tri_word(0) ^ RES_MASK);
            check("bp out_valid_held", TW'(out_valid), TW'(1));
            tick();
        end
        check("bp single_start", TW'(start_cnt - s0), TW'(1));
        out_ready = 1'b1;
        wait_done(200, "bp done_seen");
        end_frame("bp", 2, 0);

        // done held two cycles, stray frame_start mid-frame
        done_hold = 2;
        cull_mask = 8'b0000_0001;
        cull_stat[0] = 2'd1;
        begin_frame(3);
        repeat (6) tick();
        frame_start = 1'b1;
        tri_count   = CNTW'(7);
        tick();
        frame_start = 1'b0;
        wait_done(200, "hold2 done_seen");
        end_frame("hold2", 3, 1);
        repeat (3) tick();
        check("hold2 idle", TW'(state_dbg), TW'(0));
        check("hold2 no_restart", TW'(start_cnt - s0), TW'(3));
        done_hold = 1;
        cull_mask = '0;

        // full address space, no wrap
        begin_frame(8);
        wait_done(400, "full done_seen");
        end_frame("full", 8, 0);

        // asynchronous reset while waiting on the projector
        begin_frame(3);
        w = 0;
        while (state_dbg != 3'd3 && w < 50) begin
            tick();
            w++;
        end
        check("rst reach_wait", TW'(state_dbg), TW'(3));
        #2;
        rst_in = 1'b1;
        #1;
        check_all_zero("rst async");
        repeat (3) tick();
        rst_in = 1'b0;
        exp_q.delete();
        repeat (4) tick();
        check("rst no_done", TW'(done_cnt - d0), TW'(0));
        check("rst idle", TW'(state_dbg), TW'(0));
        rd = got_q.size();

        // fresh frame after reset
        begin_frame(1);
        wait_done(200, "post done_seen");
        end_frame("post", 1, 0);

        // whole-run invariants
        check("start_done_adjacent", TW'(seq_err), TW'(0));
        check("out_tri_stability", TW'(stab_err), TW'(0));
        check("proj_verts_stability", TW'(verts_err), TW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
